// File: rtl/dat_transfer_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// dat_sched_pkg : state encoding, completion status codes, recovery timing
// Rev 1.0
// ============================================================================
package dat_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_BUSY    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_ABORTED = 2'b10;

  // Cycles idle_in is held high while forcing the controller back to IDLE
  localparam int unsigned RECOVER_LEN = 2;

endpackage
`default_nettype wire

// File: rtl/dat_transfer_scheduler_if.sv
`default_nettype none
// ============================================================================
// dat_transfer_scheduler_if : host request/status and DAT controller handshake
// Rev 1.0
// ============================================================================
interface dat_transfer_scheduler_if #(
  parameter int BLOCK_W   = 4,
  parameter int TIMEOUT_W = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic                 req_multiple;
  logic [BLOCK_W-1:0]   req_blocks;
  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic                 abort;
  logic                 done;
  logic [1:0]           status;
  logic [BLOCK_W-1:0]   blocks_done;
  logic                 serial_ready;
  logic                 complete;
  logic                 block_done;
  logic                 strobe_in;
  logic                 ack_in;
  logic                 idle_in;
  logic                 writeRead;
  logic                 multiple;
  logic [BLOCK_W-1:0]   blocks;

  modport master (
    input  req_valid, req_write, req_multiple, req_blocks, timeout_cycles, abort,
    input  serial_ready, complete, block_done,
    output req_ready, done, status, blocks_done,
    output strobe_in, ack_in, idle_in, writeRead, multiple, blocks
  );

  modport slave (
    output req_valid, req_write, req_multiple, req_blocks, timeout_cycles, abort,
    output serial_ready, complete, block_done,
    input  req_ready, done, status, blocks_done,
    input  strobe_in, ack_in, idle_in, writeRead, multiple, blocks
  );
endinterface
`default_nettype wire

// File: rtl/dat_transfer_scheduler_watchdog.sv
`default_nettype none
// ============================================================================
// dat_watchdog : loadable down-counter that flags expiry when it reaches zero
// Rev 1.0
// ============================================================================
module dat_watchdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_value,
  input  logic                 enable,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - TIMEOUT_W'(1);
    end
  end

  // A zero reload value disables the watchdog entirely
  assign expired = (r_count == '0) && (load_value != '0);

endmodule
`default_nettype wire

// File: rtl/dat_transfer_scheduler.sv
`default_nettype none
// ============================================================================
// dat_transfer_scheduler : sequences host transfer requests onto the DAT
// controller with watchdog-driven recovery and bounded retry. Rev 1.0
// ============================================================================
module dat_transfer_scheduler
  import dat_sched_pkg::*;
#(
  parameter int BLOCK_W   = 4,
  parameter int TIMEOUT_W = 16,
  parameter int MAX_RETRY = 2
) (
  input logic                 sd_clock,
  input logic                 reset,
  dat_transfer_scheduler_if.master bus
);

  localparam int c_retry_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int c_rec_w   = (RECOVER_LEN > 1) ? $clog2(RECOVER_LEN) : 1;
  localparam logic [c_retry_w-1:0] c_retry_init = c_retry_w'(MAX_RETRY);
  localparam logic [c_rec_w-1:0]   c_rec_last   = c_rec_w'(RECOVER_LEN - 1);

  state_t               r_state;
  logic                 r_req_ready;
  logic                 r_done;
  logic                 r_strobe;
  logic                 r_ack;
  logic                 r_idle;
  logic                 r_write;
  logic                 r_multiple;
  logic [1:0]           r_status;
  logic [1:0]           r_result;
  logic [BLOCK_W-1:0]   r_blocks;
  logic [BLOCK_W-1:0]   r_blocks_done;
  logic [TIMEOUT_W-1:0] r_timeout;
  logic [c_retry_w-1:0] r_retries;
  logic [c_rec_w-1:0]   r_rec_cnt;

  logic w_accept;
  logic w_wd_load;
  logic w_wd_enable;
  logic w_expired;

  assign w_accept    = (r_state == ST_IDLE) && bus.req_valid && r_req_ready;
  assign w_wd_load   = (r_state == ST_ISSUE) || ((r_state == ST_BUSY) && bus.block_done);
  assign w_wd_enable = (r_state == ST_BUSY);

  dat_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk        (sd_clock),
    .rst_n      (reset),
    .load       (w_wd_load),
    .load_value (r_timeout),
    .enable     (w_wd_enable),
    .expired    (w_expired)
  );

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b0;
      r_done        <= 1'b0;
      r_strobe      <= 1'b0;
      r_ack         <= 1'b0;
      r_idle        <= 1'b0;
      r_write       <= 1'b0;
      r_multiple    <= 1'b0;
      r_status      <= STAT_OK;
      r_result      <= STAT_OK;
      r_blocks      <= '0;
      r_blocks_done <= '0;
      r_timeout     <= '0;
      r_retries     <= '0;
      r_rec_cnt     <= '0;
    end else begin
      r_strobe    <= 1'b0;
      r_ack       <= 1'b0;
      r_done      <= 1'b0;
      r_req_ready <= 1'b0;

      if ((r_state == ST_BUSY) && bus.block_done && (r_blocks_done != '1)) begin
        r_blocks_done <= r_blocks_done + BLOCK_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write       <= bus.req_write;
            r_multiple    <= bus.req_multiple;
            r_blocks      <= (bus.req_blocks == '0) ? BLOCK_W'(1) : bus.req_blocks;
            r_timeout     <= bus.timeout_cycles;
            r_blocks_done <= '0;
            r_retries     <= c_retry_init;
            r_strobe      <= 1'b1;
            r_state       <= ST_ISSUE;
          end else begin
            r_req_ready <= bus.serial_ready;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          // A block finishing on the expiry cycle reloads the watchdog instead
          if (bus.complete) begin
            r_ack   <= 1'b1;
            r_state <= ST_ACK;
          end else if (bus.abort) begin
            r_result  <= STAT_ABORTED;
            r_idle    <= 1'b1;
            r_rec_cnt <= '0;
            r_state   <= ST_RECOVER;
          end else if (w_expired && !bus.block_done) begin
            r_result  <= STAT_TIMEOUT;
            r_idle    <= 1'b1;
            r_rec_cnt <= '0;
            r_state   <= ST_RECOVER;
          end
        end
        ST_ACK: begin
          r_result <= STAT_OK;
          r_status <= STAT_OK;
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_RECOVER: begin
          if (r_rec_cnt == c_rec_last) begin
            r_idle <= 1'b0;
            // Retrying is only safe when no data has moved yet
            if ((r_result == STAT_TIMEOUT) && (r_retries != '0) && (r_blocks_done == '0)) begin
              r_retries <= r_retries - c_retry_w'(1);
              r_strobe  <= 1'b1;
              r_state   <= ST_ISSUE;
            end else begin
              r_status <= r_result;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end
          end else begin
            r_rec_cnt <= r_rec_cnt + c_rec_w'(1);
          end
        end
        ST_DONE: begin
          r_req_ready <= bus.serial_ready;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.done        = r_done;
  assign bus.status      = r_status;
  assign bus.blocks_done = r_blocks_done;
  assign bus.strobe_in   = r_strobe;
  assign bus.ack_in      = r_ack;
  assign bus.idle_in     = r_idle;
  assign bus.writeRead   = r_write;
  assign bus.multiple    = r_multiple;
  assign bus.blocks      = r_blocks;

endmodule
`default_nettype wire

// File: tb/tb_dat_transfer_scheduler.sv
`default_nettype none
// ============================================================================
// tb_dat_transfer_scheduler : vector table plus corner-case sequences, with a
// queue of expected completions checked on each done pulse. Rev 1.0
// ============================================================================
module tb_dat_transfer_scheduler;
  import dat_sched_pkg::*;

  localparam int BW = 4;
  localparam int TW = 16;

  logic sd_clock = 1'b0;
  logic reset    = 1'b1;
  always #5 sd_clock = ~sd_clock;

  dat_transfer_scheduler_if #(.BLOCK_W(BW), .TIMEOUT_W(TW)) bus();

  dat_transfer_scheduler #(
    .BLOCK_W   (BW),
    .TIMEOUT_W (TW),
    .MAX_RETRY (2)
  ) dut (
    .sd_clock (sd_clock),
    .reset    (reset),
    .bus      (bus)
  );

  typedef enum int {K_NORMAL, K_SILENT, K_PARTIAL, K_ABORT} kind_e;

  typedef struct {
    logic          wr;
    logic          mult;
    logic [BW-1:0] nblk;
    logic [TW-1:0] tmo;
    kind_e         kind;
    int            period;
    int            nbd;
    logic [1:0]    exp_st;
    logic [BW-1:0] exp_bd;
    int            exp_strobes;
    int            exp_idle;
  } vec_t;

  typedef struct {
    logic [1:0]    st;
    logic [BW-1:0] bd;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_idle = 0;
  int n_done = 0;
  int strobe_base, idle_base, done_base;
  logic [1:0]    got_status;
  logic [BW-1:0] got_blocks;

  always @(negedge sd_clock) begin
    if (bus.strobe_in) n_strobe++;
    if (bus.idle_in) n_idle++;
    if (bus.done) begin
      n_done++;
      got_status = bus.status;
      got_blocks = bus.blocks_done;
    end
  end

  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic start_req(input logic wr, input logic mult, input logic [BW-1:0] nblk,
                           input logic [TW-1:0] tmo, input logic [1:0] exp_st,
                           input logic [BW-1:0] exp_bd);
    exp_t e;
    bus.req_write      = wr;
    bus.req_multiple   = mult;
    bus.req_blocks     = nblk;
    bus.timeout_cycles = tmo;
    bus.req_valid      = 1'b1;
    for (int i = 0; i < 50 && !bus.req_ready; i++) tick();
    chk("req_ready_wait", bus.req_ready, 1);
    strobe_base = n_strobe;
    idle_base   = n_idle;
    done_base   = n_done;
    tick();
    bus.req_valid = 1'b0;
    e.st = exp_st;
    e.bd = exp_bd;
    sb_q.push_back(e);
    chk("strobe_latency", bus.strobe_in, 1);
    chk("req_ready_busy", bus.req_ready, 0);
    chk("latch_dir", bus.writeRead, wr);
    chk("latch_mult", bus.multiple, mult);
    chk("latch_blocks", bus.blocks, (nblk == 0) ? 1 : nblk);
  endtask

  task automatic wait_done(input int budget);
    exp_t e;
    for (int i = 0; i < budget && n_done == done_base; i++) tick();
    if (n_done == done_base) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("status", got_status, e.st);
        chk("blocks_done", got_blocks, e.bd);
        tick();
        tick();
        chk("status_held", bus.status, e.st);
      end else begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected: got done expected none");
      end
    end
    chk("done_count", n_done - done_base, 1);
  endtask

  task automatic pulse_block();
    bus.block_done = 1'b1;
    tick();
    bus.block_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    start_req(v.wr, v.mult, v.nblk, v.tmo, v.exp_st, v.exp_bd);
    case (v.kind)
      K_NORMAL: begin
        for (int b = 0; b < v.nbd; b++) begin
          repeat (v.period - 1) tick();
          pulse_block();
        end
        repeat (3) tick();
        bus.complete = 1'b1;
        tick();
        bus.complete = 1'b0;
        chk("ack_latency", bus.ack_in, 1);
        tick();
        chk("done_latency", bus.done, 1);
      end
      K_PARTIAL: begin
        repeat (3) tick();
        pulse_block();
      end
      K_ABORT: begin
        repeat (1 + v.period) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
      end
      default: ;
    endcase
    wait_done(300);
    chk("strobe_count", n_strobe - strobe_base, v.exp_strobes);
    chk("idle_cycles", n_idle - idle_base, v.exp_idle);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'd1,  16'd100, K_NORMAL,  20, 1,  STAT_OK,      4'd1,  1, 0};
    vecs[1] = '{1'b0, 1'b1, 4'd3,  16'd60,  K_NORMAL,  50, 3,  STAT_OK,      4'd3,  1, 0};
    vecs[2] = '{1'b0, 1'b0, 4'd1,  16'd10,  K_SILENT,  0,  0,  STAT_TIMEOUT, 4'd0,  3, 6};
    vecs[3] = '{1'b1, 1'b1, 4'd4,  16'd10,  K_PARTIAL, 0,  1,  STAT_TIMEOUT, 4'd1,  1, 2};
    vecs[4] = '{1'b1, 1'b1, 4'd2,  16'd30,  K_ABORT,   5,  0,  STAT_ABORTED, 4'd0,  1, 2};
    vecs[5] = '{1'b0, 1'b1, 4'd15, 16'd0,   K_NORMAL,  3,  17, STAT_OK,      4'd15, 1, 0};
    vecs[6] = '{1'b0, 1'b0, 4'd1,  16'd0,   K_ABORT,   40, 0,  STAT_ABORTED, 4'd0,  1, 2};

    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_multiple   = 1'b0;
    bus.req_blocks     = '0;
    bus.timeout_cycles = '0;
    bus.abort          = 1'b0;
    bus.serial_ready   = 1'b1;
    bus.complete       = 1'b0;
    bus.block_done     = 1'b0;

    #2 reset = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {bus.req_ready, bus.done, bus.status, bus.blocks_done, bus.strobe_in,
                          bus.ack_in, bus.idle_in, bus.writeRead, bus.multiple, bus.blocks}, 0);
    reset = 1'b1;
    tick();
    chk("req_ready_after_reset", bus.req_ready, 1);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Expiry timing: idle_in exactly 2 cycles, then a retry strobe
    start_req(1'b0, 1'b0, 4'd1, 16'd10, STAT_TIMEOUT, 4'd0);
    repeat (11) tick();
    chk("idle_early", bus.idle_in, 0);
    tick();
    chk("idle_rise", bus.idle_in, 1);
    tick();
    chk("idle_second", bus.idle_in, 1);
    tick();
    chk("idle_fall", bus.idle_in, 0);
    chk("retry_strobe", bus.strobe_in, 1);
    wait_done(300);
    chk("retry_strobes", n_strobe - strobe_base, 3);

    // block_done on the expiry cycle reloads instead of timing out
    start_req(1'b1, 1'b0, 4'd1, 16'd10, STAT_OK, 4'd1);
    repeat (11) tick();
    pulse_block();
    chk("reload_wins", bus.idle_in, 0);
    bus.complete = 1'b1;
    tick();
    bus.complete = 1'b0;
    chk("reload_ack", bus.ack_in, 1);
    wait_done(50);

    // complete and abort together: complete wins
    start_req(1'b0, 1'b1, 4'd2, 16'd50, STAT_OK, 4'd0);
    repeat (4) tick();
    bus.abort    = 1'b1;
    bus.complete = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.complete = 1'b0;
    chk("abort_vs_complete_ack", bus.ack_in, 1);
    chk("abort_vs_complete_idle", bus.idle_in, 0);
    wait_done(50);

    // Reset mid-transfer: outputs clear at once and no done is produced
    start_req(1'b1, 1'b1, 4'd3, 16'd100, STAT_OK, 4'd0);
    repeat (4) tick();
    pulse_block();
    chk("progress_mid", bus.blocks_done, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.req_ready, bus.done, bus.status, bus.blocks_done, bus.strobe_in,
                                bus.ack_in, bus.idle_in, bus.writeRead, bus.multiple, bus.blocks}, 0);
    void'(sb_q.pop_back());
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("no_done_on_reset", n_done - done_base, 0);

    start_req(1'b1, 1'b0, 4'd0, 16'd100, STAT_OK, 4'd1);
    repeat (4) tick();
    pulse_block();
    repeat (2) tick();
    bus.complete = 1'b1;
    tick();
    bus.complete = 1'b0;
    chk("zero_blocks_ack", bus.ack_in, 1);
    wait_done(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
